// File: rtl/vert_ucode_quicksort_pkg.sv
// Shared types and constants for the vertical-microcode quicksort bank engines.
// Both the enqueue and dequeue engines import this package.
package vert_ucode_quicksort_pkg;

    localparam int N                  = 16;
    localparam int W                  = 32;
    localparam int BANK_N             = 2;
    localparam int UNLOAD_BUF_D       = 4;
    localparam int DEQUEUE_FSM_BUSY_B = 2;

    // The signed count carries one bit beyond N so that N itself and
    // oversized requests remain representable before clamping.
    typedef logic signed [$clog2(N)+1:0]     n_t;
    typedef logic [$clog2(N):0]              cnt_t;
    typedef logic [$clog2(N)-1:0]            addr_t;
    typedef logic [$clog2(BANK_N)-1:0]       bank_n_t;
    typedef logic [W-1:0]                    w_t;
    typedef logic [$clog2(UNLOAD_BUF_D):0]   occ_t;

    typedef enum logic [2:0] {
        DEQUEUE_FSM_IDLE  = 3'b000,
        DEQUEUE_FSM_EMIT  = 3'b101,
        DEQUEUE_FSM_DRAIN = 3'b110
    } dequeue_fsm_t;

    typedef struct packed {
        logic lst;
        w_t   dat;
    } buf_ent_t;

    // Non-positive counts mean an empty bank; anything above N is capped at N.
    function automatic cnt_t clamp_count(input n_t n);
        if (n < n_t'(1))
            return '0;
        if (n > n_t'(N))
            return cnt_t'(N);
        return cnt_t'(n);
    endfunction

endpackage

// File: rtl/vert_ucode_quicksort_unload_buf.sv
// Small output FIFO for the unload engine: holds {lst, dat} words returned by
// the bank memory until the downstream stream accepts them.
module vert_ucode_quicksort_unload_buf
    import vert_ucode_quicksort_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  buf_ent_t push_ent,
    input  logic     pop,
    output occ_t     occ,
    output logic     head_vld,
    output buf_ent_t head_ent
);

    localparam int PW = $clog2(UNLOAD_BUF_D);

    typedef logic [PW-1:0] ptr_t;

    buf_ent_t mem [UNLOAD_BUF_D];
    ptr_t     wr_ptr;
    ptr_t     rd_ptr;
    logic     do_pop;

    assign do_pop = pop && head_vld;

    // NOTE: the storage array has no reset; only pointers and occupancy do,
    // and the head is forced to zero while empty so stale entries never leak.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

    assign head_vld = (occ != '0);
    assign head_ent = head_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/vert_ucode_quicksort_unload.sv
// Dequeue engine: reads a sorted bank in address order and streams it out,
// flagging the last word and pulsing done so the bank can return to idle.
module vert_ucode_quicksort_unload
    import vert_ucode_quicksort_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    start_vld,
    input  bank_n_t start_bank,
    input  n_t      start_n,
    output logic    start_rdy,
    output logic    rd_en,
    output bank_n_t rd_bank,
    output addr_t   rd_addr,
    input  w_t      rd_dat,
    output logic    out_vld,
    output w_t      out_dat,
    output logic    out_lst,
    input  logic    out_rdy,
    output logic    done_vld,
    output bank_n_t done_bank,
    output logic    busy
);

    dequeue_fsm_t state;
    addr_t        last_addr;
    logic         rd_pend;
    logic         rd_pend_lst;
    occ_t         occ;
    buf_ent_t     push_ent;
    buf_ent_t     head_ent;
    logic         accept;
    logic         rd_is_last;
    logic         pop;
    cnt_t         start_cnt;

    assign start_cnt = clamp_count(start_n);
    assign start_rdy = (state == DEQUEUE_FSM_IDLE);
    assign accept    = start_vld && start_rdy;
    assign busy      = state[DEQUEUE_FSM_BUSY_B];

    // Issue only when every outstanding word is guaranteed a FIFO slot; this
    // depends on registered state alone, never on out_rdy.
    assign rd_en      = (state == DEQUEUE_FSM_EMIT) &&
                        ((occ + occ_t'(rd_pend)) < occ_t'(UNLOAD_BUF_D));
    assign rd_is_last = rd_en && (rd_addr == last_addr);
    assign pop        = out_vld && out_rdy;

    assign push_ent = '{lst: rd_pend_lst, dat: rd_dat};

    vert_ucode_quicksort_unload_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_pend),
        .push_ent (push_ent),
        .pop      (pop),
        .occ      (occ),
        .head_vld (out_vld),
        .head_ent (head_ent)
    );

    assign out_dat = head_ent.dat;
    assign out_lst = head_ent.lst;

    // NOTE: all state here is assigned with <= so every register samples the
    // pre-edge values regardless of statement order within the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= DEQUEUE_FSM_IDLE;
            rd_bank     <= '0;
            rd_addr     <= '0;
            last_addr   <= '0;
            rd_pend     <= 1'b0;
            rd_pend_lst <= 1'b0;
            done_vld    <= 1'b0;
            done_bank   <= '0;
        end else begin
            done_vld    <= 1'b0;
            rd_pend     <= rd_en;
            rd_pend_lst <= rd_is_last;
            if (rd_en)
                rd_addr <= rd_addr + 1'b1;

            case (state)
                DEQUEUE_FSM_IDLE: begin
                    if (accept) begin
                        rd_bank <= start_bank;
                        rd_addr <= '0;
                        if (start_cnt == '0) begin
                            done_vld  <= 1'b1;
                            done_bank <= start_bank;
                        end else begin
                            last_addr <= addr_t'(start_cnt - 1'b1);
                            state     <= DEQUEUE_FSM_EMIT;
                        end
                    end
                end
                DEQUEUE_FSM_EMIT: begin
                    if (rd_is_last)
                        state <= DEQUEUE_FSM_DRAIN;
                end
                DEQUEUE_FSM_DRAIN: begin
                    if (pop && out_lst) begin
                        state     <= DEQUEUE_FSM_IDLE;
                        done_vld  <= 1'b1;
                        done_bank <= rd_bank;
                    end
                end
                default: state <= DEQUEUE_FSM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vert_ucode_quicksort_unload.sv
// Self-checking bench for the quicksort unload engine: a behavioural bank
// memory, a word scoreboard, and one task per scenario.
`timescale 1ns/1ps
module tb_vert_ucode_quicksort_unload;
    import vert_ucode_quicksort_pkg::*;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    start_vld;
    bank_n_t start_bank;
    n_t      start_n;
    logic    start_rdy;
    logic    rd_en;
    bank_n_t rd_bank;
    addr_t   rd_addr;
    w_t      rd_dat = '0;
    logic    out_vld;
    w_t      out_dat;
    logic    out_lst;
    logic    out_rdy;
    logic    done_vld;
    bank_n_t done_bank;
    logic    busy;

    always #5 clk = ~clk;

    vert_ucode_quicksort_unload dut (
        .clk        (clk),
        .rst        (rst),
        .start_vld  (start_vld),
        .start_bank (start_bank),
        .start_n    (start_n),
        .start_rdy  (start_rdy),
        .rd_en      (rd_en),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .rd_dat     (rd_dat),
        .out_vld    (out_vld),
        .out_dat    (out_dat),
        .out_lst    (out_lst),
        .out_rdy    (out_rdy),
        .done_vld   (done_vld),
        .done_bank  (done_bank),
        .busy       (busy)
    );

    // Bank memory: one-cycle read latency.
    w_t mem [BANK_N][N];
    always @(posedge clk) begin
        if (rd_en)
            rd_dat <= mem[rd_bank][rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [W:0] exp_q [$];
    int rd_cnt = 0, words = 0, vld_cycles = 0, done_cnt = 0, max_addr = -1;
    int acc_cyc = 0, first_rd_cyc = -1, first_out_cyc = -1, last_out_cyc = 0, done_cyc = 0;
    int issued = 0, popped = 0;
    int last_done_bank = 0;
    bit hold_pend = 1'b0;
    logic [W:0] hold_ent;

    task automatic monitor();
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                issued    = 0;
                popped    = 0;
                hold_pend = 1'b0;
                continue;
            end
            if (start_vld && start_rdy) begin
                acc_cyc       = cyc;
                first_rd_cyc  = -1;
                first_out_cyc = -1;
            end
            if (rd_en) begin
                vectors++;
                if (issued - popped >= UNLOAD_BUF_D) begin
                    miscompares++;
                    $display("FAIL credit: rd_en with %0d outstanding, limit %0d", issued - popped, UNLOAD_BUF_D);
                end
                issued++;
                rd_cnt++;
                if (int'(rd_addr) > max_addr)
                    max_addr = int'(rd_addr);
                if (first_rd_cyc < 0)
                    first_rd_cyc = cyc;
            end
            if (hold_pend) begin
                vectors++;
                if ({out_vld, out_lst, out_dat} !== {1'b1, hold_ent}) begin
                    miscompares++;
                    $display("FAIL stall_hold: got vld=%0b %h want vld=1 %h", out_vld, {out_lst, out_dat}, hold_ent);
                end
            end
            hold_pend = out_vld && !out_rdy;
            hold_ent  = {out_lst, out_dat};
            if (out_vld) begin
                vld_cycles++;
                if (first_out_cyc < 0)
                    first_out_cyc = cyc;
            end
            if (out_vld && out_rdy) begin
                popped++;
                words++;
                last_out_cyc = cyc;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL word: got %h want no word", {out_lst, out_dat});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_lst, out_dat} !== e) begin
                        miscompares++;
                        $display("FAIL word: got lst/dat %h want %h", {out_lst, out_dat}, e);
                    end
                end
            end
            if (done_vld) begin
                done_cnt++;
                done_cyc       = cyc;
                last_done_bank = int'(done_bank);
                vectors++;
                if (start_rdy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL done_rdy: start_rdy got %b want 1", start_rdy);
                end
            end
        end
    endtask

    // Queue the expected stream, then present the command for one cycle.
    task automatic push_expected(input int b, input int n);
        int cnt;
        cnt = (n <= 0) ? 0 : ((n > N) ? N : n);
        for (int i = 0; i < cnt; i++)
            exp_q.push_back({(i == cnt - 1), mem[b][i]});
    endtask

    task automatic drive_cmd(input int b, input int n);
        push_expected(b, n);
        start_vld  = 1'b1;
        start_bank = bank_n_t'(b);
        start_n    = n_t'(n);
        @(posedge clk);
        #1;
        start_vld = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input bit toggle);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge clk);
            #1;
            if (toggle)
                out_rdy = ~out_rdy;
            k++;
        end
        vectors++;
        if (done_cnt < target) begin
            miscompares++;
            $display("FAIL done_timeout: done count got %0d want %0d", done_cnt, target);
        end
    endtask

    task automatic test_reset();
        logic [43:0] exp_idle;
        exp_idle     = '0;
        exp_idle[43] = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({start_rdy, rd_en, rd_addr, rd_bank, out_vld, out_dat, out_lst, done_vld, done_bank, busy} !== exp_idle) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h",
                     {start_rdy, rd_en, rd_addr, rd_bank, out_vld, out_dat, out_lst, done_vld, done_bank, busy}, exp_idle);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({start_rdy, rd_en, busy, out_vld, done_vld} !== 5'b10000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b want 10000", {start_rdy, rd_en, busy, out_vld, done_vld});
        end
    endtask

    task automatic test_basic();
        int w0, d0;
        mem[1][0] = 32'd50;
        mem[1][1] = 32'd40;
        mem[1][2] = 32'd30;
        mem[1][3] = 32'd20;
        mem[1][4] = 32'd10;
        out_rdy = 1'b1;
        w0 = words;
        d0 = done_cnt;
        drive_cmd(1, 5);
        wait_done(d0 + 1, 100, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (first_rd_cyc !== acc_cyc + 1) begin
            miscompares++;
            $display("FAIL basic_first_rd: got T+%0d want T+1", first_rd_cyc - acc_cyc);
        end
        vectors++;
        if (first_out_cyc !== acc_cyc + 3) begin
            miscompares++;
            $display("FAIL basic_first_out: got T+%0d want T+3", first_out_cyc - acc_cyc);
        end
        vectors++;
        if (last_out_cyc !== acc_cyc + 7) begin
            miscompares++;
            $display("FAIL basic_last_out: got T+%0d want T+7", last_out_cyc - acc_cyc);
        end
        vectors++;
        if (done_cyc !== acc_cyc + 8) begin
            miscompares++;
            $display("FAIL basic_done_time: got T+%0d want T+8", done_cyc - acc_cyc);
        end
        vectors++;
        if (last_done_bank !== 1) begin
            miscompares++;
            $display("FAIL basic_done_bank: got %0d want 1", last_done_bank);
        end
        vectors++;
        if (words - w0 !== 5 || done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL basic_count: words %0d dones %0d want 5 1", words - w0, done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int w0, d0, r0;
        out_rdy = 1'b0;
        w0 = words;
        d0 = done_cnt;
        r0 = rd_cnt;
        drive_cmd(0, 16);
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (rd_cnt - r0 !== UNLOAD_BUF_D || out_vld !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_fill: reads %0d vld %b busy %b want %0d 1 1", rd_cnt - r0, out_vld, busy, UNLOAD_BUF_D);
        end
        wait_done(d0 + 1, 200, 1'b1);
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (words - w0 !== 16 || done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL toggle_count: words %0d dones %0d left %0d want 16 1 0", words - w0, done_cnt - d0, exp_q.size());
        end
        vectors++;
        if (last_done_bank !== 0) begin
            miscompares++;
            $display("FAIL toggle_done_bank: got %0d want 0", last_done_bank);
        end
    endtask

    task automatic test_empty();
        int n_vals [2];
        int r0, v0, d0;
        n_vals[0] = 0;
        n_vals[1] = -3;
        out_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r0 = rd_cnt;
            v0 = vld_cycles;
            d0 = done_cnt;
            drive_cmd(1, n_vals[i]);
            wait_done(d0 + 1, 20, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            vectors++;
            if (done_cyc !== acc_cyc + 1 || last_done_bank !== 1) begin
                miscompares++;
                $display("FAIL empty_done n=%0d: got T+%0d bank %0d want T+1 bank 1", n_vals[i], done_cyc - acc_cyc, last_done_bank);
            end
            vectors++;
            if (rd_cnt - r0 !== 0 || vld_cycles - v0 !== 0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL empty_activity n=%0d: reads %0d vld %0d busy %b want 0 0 0", n_vals[i], rd_cnt - r0, vld_cycles - v0, busy);
            end
        end
    endtask

    task automatic test_clamp();
        int w0, r0, d0;
        out_rdy  = 1'b1;
        w0       = words;
        r0       = rd_cnt;
        d0       = done_cnt;
        max_addr = -1;
        drive_cmd(1, 20);
        wait_done(d0 + 1, 100, 1'b0);
        #1;
        vectors++;
        if (words - w0 !== 16 || rd_cnt - r0 !== 16 || max_addr !== 15 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL clamp: words %0d reads %0d max_addr %0d want 16 16 15", words - w0, rd_cnt - r0, max_addr);
        end
        vectors++;
        if (done_cyc !== acc_cyc + 3 + 16) begin
            miscompares++;
            $display("FAIL clamp_done_time: got T+%0d want T+19", done_cyc - acc_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int w0, d0, d1, a2;
        out_rdy = 1'b1;
        w0 = words;
        d0 = done_cnt;
        push_expected(0, 3);
        start_vld  = 1'b1;
        start_bank = bank_n_t'(0);
        start_n    = n_t'(3);
        @(posedge clk);
        #1;
        // Second command held pending; it must be taken in the done cycle.
        push_expected(1, 4);
        start_bank = bank_n_t'(1);
        start_n    = n_t'(4);
        wait_done(d0 + 1, 50, 1'b0);
        start_vld = 1'b0;
        d1 = done_cyc;
        a2 = acc_cyc;
        vectors++;
        if (a2 !== d1) begin
            miscompares++;
            $display("FAIL b2b_accept: accepted at %0d want %0d", a2, d1);
        end
        wait_done(d0 + 2, 50, 1'b0);
        #1;
        vectors++;
        if (first_rd_cyc !== a2 + 1 || done_cyc !== a2 + 7 || last_done_bank !== 1) begin
            miscompares++;
            $display("FAIL b2b_second: rd T+%0d done T+%0d bank %0d want T+1 T+7 1", first_rd_cyc - a2, done_cyc - a2, last_done_bank);
        end
        vectors++;
        if (words - w0 !== 7 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL b2b_words: got %0d left %0d want 7 0", words - w0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int w0, d0, k;
        logic [43:0] exp_idle;
        exp_idle     = '0;
        exp_idle[43] = 1'b1;
        out_rdy = 1'b1;
        w0 = words;
        drive_cmd(0, 8);
        k = 0;
        while (words - w0 < 3 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({start_rdy, rd_en, rd_addr, rd_bank, out_vld, out_dat, out_lst, done_vld, done_bank, busy} !== exp_idle) begin
            miscompares++;
            $display("FAIL mid_reset_state: got %h want %h",
                     {start_rdy, rd_en, rd_addr, rd_bank, out_vld, out_dat, out_lst, done_vld, done_bank, busy}, exp_idle);
        end
        vectors++;
        if (words - w0 !== 3) begin
            miscompares++;
            $display("FAIL mid_reset_words: got %0d want 3", words - w0);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        w0 = words;
        d0 = done_cnt;
        drive_cmd(1, 2);
        wait_done(d0 + 1, 50, 1'b0);
        #1;
        vectors++;
        if (words - w0 !== 2 || exp_q.size() !== 0 || last_done_bank !== 1 || done_cyc !== acc_cyc + 5) begin
            miscompares++;
            $display("FAIL post_reset_unload: words %0d left %0d bank %0d done T+%0d want 2 0 1 T+5",
                     words - w0, exp_q.size(), last_done_bank, done_cyc - acc_cyc);
        end
    endtask

    initial begin
        start_vld  = 1'b0;
        start_bank = '0;
        start_n    = '0;
        out_rdy    = 1'b0;
        for (int b = 0; b < BANK_N; b++)
            for (int a = 0; a < N; a++)
                mem[b][a] = 32'h0100_0000 * (b + 1) + 32'h11 * a + 32'd7;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
